// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_pkg
// Purpose  : Shared FSM state and mode encodings for the mux_scan selector.
// Revision : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_next_ch.sv
`default_nettype none
// ============================================================================
// Module   : mux_next_ch
// Purpose  : Combinational finder for the next enabled channel above an index,
//            plus the lowest enabled channel and an any-enabled flag.
// Revision : 1.0 - initial release
// ============================================================================
module mux_next_ch
    import mux_scan_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_cur,
    output logic [IDX_W-1:0] o_next,
    output logic             o_found,
    output logic [IDX_W-1:0] o_lowest,
    output logic             o_any
);

    // Walking downward lets the last hit win, leaving the smallest qualifying index.
    always_comb begin
        o_next   = '0;
        o_found  = 1'b0;
        o_lowest = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                o_lowest = IDX_W'(k);
                if (k > int'(i_cur)) begin
                    o_next  = IDX_W'(k);
                    o_found = 1'b1;
                end
            end
        end
    end

    assign o_any = |i_mask;

endmodule
`default_nettype wire

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Purpose  : NUM_IN:1 channel selector with registered valid/ready output,
//            direct and ascending-scan modes. Optional continuous scan with a
//            stop input is enabled by defining MUX_SCAN_CONT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int NUM_IN = 16,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic [NUM_IN-1:0]        ch_mask,
    input  logic                     start,
`ifdef MUX_SCAN_CONT_EN
    input  logic                     stop,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err
);

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_data,  w_data_nxt;
    logic [SEL_W-1:0]    r_ch,    w_ch_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_last,  w_last_nxt;
    logic                r_busy,  w_busy_nxt;
    logic                r_err,   w_err_nxt;
    logic [NUM_IN-1:0]   r_mask,  w_mask_nxt;

    logic [DATA_W-1:0]   w_chan [NUM_IN];
    logic [NUM_IN-1:0]   w_mask_sel;
    logic [SEL_W-1:0]    w_next, w_lowest, w_scan_ch, w_clamp, w_pick;
    logic                w_found, w_any, w_more, w_wrap;
    logic [DATA_W-1:0]   w_pick_data;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign w_chan[k] = in_data[k*DATA_W +: DATA_W];
    end

    // In IDLE the finder looks at the live mask; during a scan, at the snapshot.
    assign w_mask_sel = (r_state == ST_IDLE) ? ch_mask : r_mask;

    mux_next_ch #(
        .N     (NUM_IN),
        .IDX_W (SEL_W)
    ) u_next_ch (
        .i_mask   (w_mask_sel),
        .i_cur    (r_ch),
        .o_next   (w_next),
        .o_found  (w_found),
        .o_lowest (w_lowest),
        .o_any    (w_any)
    );

    assign w_scan_ch   = ((r_state == ST_IDLE) || r_last) ? w_lowest : w_next;
    assign w_more      = (w_mask_sel >> w_scan_ch) > NUM_IN'(1);
    assign w_clamp     = (int'(sel) > NUM_IN - 1) ? SEL_W'(NUM_IN - 1) : sel;
    assign w_pick      = ((r_state == ST_IDLE) && (mode == MODE_DIRECT)) ? w_clamp : w_scan_ch;
    assign w_pick_data = w_chan[w_pick];

`ifdef MUX_SCAN_CONT_EN
    logic r_mode,      w_mode_nxt;
    logic r_stop_pend, w_stop_pend_nxt;

    assign w_wrap = (r_mode == MODE_SCAN) && !(r_stop_pend || stop);
`else
    assign w_wrap = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_ch_nxt    = r_ch;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_err_nxt   = 1'b0;
        w_mask_nxt  = r_mask;
`ifdef MUX_SCAN_CONT_EN
        w_mode_nxt      = r_mode;
        w_stop_pend_nxt = r_stop_pend;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((mode == MODE_DIRECT) || w_any) begin
                        w_data_nxt  = w_pick_data;
                        w_ch_nxt    = w_pick;
                        w_last_nxt  = (mode == MODE_DIRECT) ? 1'b1 : !w_more;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_mask_nxt  = ch_mask;
                        w_state_nxt = ST_EMIT;
`ifdef MUX_SCAN_CONT_EN
                        w_mode_nxt  = mode;
`endif
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
`ifdef MUX_SCAN_CONT_EN
                if (stop) begin
                    w_stop_pend_nxt = 1'b1;
                end
`endif
                if (r_valid && out_ready) begin
                    if ((!r_last && w_found) || (r_last && w_wrap)) begin
                        w_data_nxt = w_pick_data;
                        w_ch_nxt   = w_pick;
                        w_last_nxt = !w_more;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
`ifdef MUX_SCAN_CONT_EN
                        w_stop_pend_nxt = 1'b0;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_ch    <= w_ch_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

`ifdef MUX_SCAN_CONT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= MODE_DIRECT;
            r_stop_pend <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end
`endif

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan
// Purpose  : Randomised scoreboard bench for mux_scan (16 x 8-bit channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

    localparam int NI = 16;
    localparam int DW = 8;
    localparam int SW = 4;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic [NI*DW-1:0] in_data = '0;
    logic [SW-1:0]    sel     = '0;
    logic             mode    = 1'b0;
    logic [NI-1:0]    ch_mask = '0;
    logic             start   = 1'b0;
    logic             out_ready = 1'b0;
`ifdef MUX_SCAN_CONT_EN
    logic             stop    = 1'b1;
`endif
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_ch;
    logic             out_valid, out_last, busy, err;

    mux_scan #(.NUM_IN(NI), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .start     (start),
`ifdef MUX_SCAN_CONT_EN
        .stop      (stop),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] ch;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    errors   = 0;
    int    checks   = 0;
    int    rdy_mode = 0;   // 0 always ready, 1 random, 2 toggle, 3 stalled
    int    n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] chan(input int k);
        return in_data[k*DW +: DW];
    endfunction

    // Reference: one beat per enabled channel in ascending order, last on the highest.
    function automatic void model(input logic m, input logic [SW-1:0] s,
                                  input logic [NI-1:0] msk, input int passes);
        int c;
        int hi;
        if (m == 1'b0) begin
            c = (int'(s) > NI - 1) ? NI - 1 : int'(s);
            exp_q.push_back('{chan(c), SW'(c), 1'b1});
        end else begin
            hi = -1;
            for (int k = 0; k < NI; k++) if (msk[k]) hi = k;
            for (int p = 0; p < passes; p++)
                for (int k = 0; k < NI; k++)
                    if (msk[k]) exp_q.push_back('{chan(k), SW'(k), (k == hi)});
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 7);
                2:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every presented beat must match the head of the queue; pop on accept.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: ch %0d data %0h appeared, expected no beat", out_ch, out_data);
                end else begin
                    chk("beat{data,ch,last}", {out_data, out_ch, out_last}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input logic m, input logic [SW-1:0] s, input logic [NI-1:0] msk,
                          input int hold, input bit inject, output int cyc);
        int g;
        cyc = 0;
        @(posedge clk);
        #1;
        g = 0;
        while (busy && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
        mode    = m;
        sel     = s;
        ch_mask = msk;
        if (hold > 0) rdy_mode = 3;
        model(m, s, msk, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (m == 1'b1 && msk == '0) begin
            @(negedge clk);
            chk("err_pulse{err,valid,busy}", {err, out_valid, busy}, 3'b100);
            @(negedge clk);
            chk("err_clear{err,valid,busy}", {err, out_valid, busy}, 3'b000);
            return;
        end
        @(negedge clk);
        chk("start_latency{valid,busy}", {out_valid, busy}, 2'b11);
        @(posedge clk);
        #1;
        cyc = 1;
        if (inject && busy) begin
            start   = 1'b1;
            mode    = ~m;
            sel     = ~s;
            ch_mask = '1;
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
        end
        while (busy && cyc < 400) begin
            if (hold > 0) begin
                if (cyc >= hold) rdy_mode = 0;
                else in_data = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("op_done_busy", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_outputs{valid,last}", {out_valid, out_last}, 2'b00);
    endtask

    task automatic ramp_data();
        for (int k = 0; k < NI; k++) in_data[k*DW +: DW] = 8'hA0 + 8'(k);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ramp_data();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {out_valid, out_last, busy, err, out_data, out_ch}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_mode = 0;
        run_op(1'b0, 4'd5, '0, 0, 1'b0, n);
        chk("direct_busy_cycles", n, 1);

        run_op(1'b0, 4'd15, '0, 5, 1'b0, n);
        rdy_mode = 0;
        ramp_data();

        run_op(1'b1, 4'd0, 16'h8421, 0, 1'b0, n);
        chk("scan_1beat_per_cycle", n, 4);

        rdy_mode = 2;
        run_op(1'b1, 4'd0, 16'h0006, 0, 1'b1, n);
        rdy_mode = 0;

        run_op(1'b1, 4'd0, 16'h0000, 0, 1'b0, n);

        // Reset in the middle of a full scan.
        @(posedge clk);
        #1;
        mode    = 1'b1;
        ch_mask = '1;
        model(1'b1, '0, '1, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_midscan", {out_valid, out_last, busy, err, out_data, out_ch}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_beats_after_reset{valid,busy}", {out_valid, busy}, 2'b00);

        for (int i = 0; i < 40; i++) begin
            logic [NI-1:0] msk;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            rdy_mode = $urandom_range(0, 1);
            msk      = ($urandom_range(0, 7) == 0) ? '0 : NI'($urandom);
            run_op(1'($urandom_range(0, 1)), SW'($urandom), msk, 0, 1'b0, n);
        end
        rdy_mode = 0;

`ifdef MUX_SCAN_CONT_EN
        ramp_data();
        @(posedge clk);
        #1;
        stop    = 1'b0;
        mode    = 1'b1;
        ch_mask = 16'h0003;
        model(1'b1, '0, 16'h0003, 3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cont_stop_busy", busy, 0);
        chk("cont_queue_drained", exp_q.size(), 0);
        stop = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
